lsu_commit_arb: RTL and testbench

- Downstream neighbour of the LSU. Merges the LSU's two commit streams (load commit, store commit) into the single LSU commit port feeding the core's writeback/commit stage.
- Arbitrates round-robin between the two streams.
- Never interleaves a multi-beat packet (eop=0 beats) with the other stream.
- Registers the output with full throughput and maintains commit performance counters.

---
 rtl/lsu_commit_if.sv | 25 ++
 rtl/lsu_commit_arb.sv | 135 +++++++++++++
 tb/tb_lsu_commit_arb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_commit_if.sv
// lsu_commit_if: one LSU commit beat stream (valid/ready handshake plus payload).
//   valid  : beat present          ready : beat accepted this cycle
//   wid    : warp id               tmask : thread mask
//   pc     : instruction PC        rd    : destination register
//   wb     : writeback enable      data  : lane i at [32i+:32]
//   eop    : last beat of the packet
// master drives valid/payload and samples ready; slave does the reverse.
interface lsu_commit_if #(
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5
);
    logic                      valid;
    logic                      ready;
    logic [NW_BITS-1:0]        wid;
    logic [NUM_THREADS-1:0]    tmask;
    logic [31:0]               pc;
    logic [NR_BITS-1:0]        rd;
    logic                      wb;
    logic [NUM_THREADS*32-1:0] data;
    logic                      eop;

    modport master (output valid, wid, tmask, pc, rd, wb, data, eop, input ready);
    modport slave  (input valid, wid, tmask, pc, rd, wb, data, eop, output ready);
endinterface

// File: rtl/lsu_commit_arb.sv
// lsu_commit_arb: merges the LSU load-commit and store-commit streams into the
// single commit port. Round-robin between streams, multi-beat packets (eop=0
// beats) are never interleaved, output is registered at full throughput.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   ld_if  (slave)     : load commit stream
//   st_if  (slave)     : store commit stream
//   out_if (master)    : merged commit stream
//   perf_ld_beats      : accepted load beats (wraps)
//   perf_st_beats      : accepted store beats (wraps)
//   perf_stall_cycles  : cycles with out valid and not ready (wraps)
//
// state        | meaning
// -------------+---------------------------------------------------------
// ARB_OPEN     | no packet in flight, round-robin between valid streams
// ARB_LOCK_LD  | load packet in progress, only the load stream may fire
// ARB_LOCK_ST  | store packet in progress, only the store stream may fire
module lsu_commit_arb #(
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5,
    parameter int PERF_W      = 44
) (
    input  logic              clk,
    input  logic              reset,
    lsu_commit_if.slave       ld_if,
    lsu_commit_if.slave       st_if,
    lsu_commit_if.master      out_if,
    output logic [PERF_W-1:0] perf_ld_beats,
    output logic [PERF_W-1:0] perf_st_beats,
    output logic [PERF_W-1:0] perf_stall_cycles
);

    localparam int PAY_W = NW_BITS + NUM_THREADS + 32 + NR_BITS + 1 + NUM_THREADS*32 + 1;
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    typedef enum logic [1:0] {
        ARB_OPEN    = 2'd0,
        ARB_LOCK_LD = 2'd1,
        ARB_LOCK_ST = 2'd2
    } arb_state_t;

    arb_state_t       state;
    logic             last_grant_st;  // 1: store stream won the last grant
    logic             out_valid_q;
    logic [PAY_W-1:0] out_pay;

    logic [PAY_W-1:0] ld_pay;
    logic [PAY_W-1:0] st_pay;
    logic [PAY_W-1:0] gnt_pay;
    logic             grant_ld;
    logic             grant_st;
    logic             stall;
    logic             enable;
    logic             fire_ld;
    logic             fire_st;
    logic             fire;
    logic             gnt_eop;

    assign ld_pay = {ld_if.wid, ld_if.tmask, ld_if.pc, ld_if.rd, ld_if.wb, ld_if.data, ld_if.eop};
    assign st_pay = {st_if.wid, st_if.tmask, st_if.pc, st_if.rd, st_if.wb, st_if.data, st_if.eop};

    assign {out_if.wid, out_if.tmask, out_if.pc, out_if.rd,
            out_if.wb, out_if.data, out_if.eop} = out_pay;
    assign out_if.valid = out_valid_q;

    assign stall  = out_valid_q & ~out_if.ready;
    assign enable = ~stall;

    // A grant is only ever raised for a valid stream, so ready implies fire.
    always_comb begin
        grant_ld = 1'b0;
        grant_st = 1'b0;
        case (state)
            ARB_LOCK_LD: grant_ld = ld_if.valid;
            ARB_LOCK_ST: grant_st = st_if.valid;
            default: begin
                if (ld_if.valid && st_if.valid) begin
                    grant_ld = last_grant_st;
                    grant_st = ~last_grant_st;
                end else begin
                    grant_ld = ld_if.valid;
                    grant_st = st_if.valid;
                end
            end
        endcase
    end

    assign ld_if.ready = grant_ld & enable;
    assign st_if.ready = grant_st & enable;
    assign fire_ld     = ld_if.ready;
    assign fire_st     = st_if.ready;
    assign fire        = fire_ld | fire_st;
    assign gnt_pay     = fire_st ? st_pay : ld_pay;
    assign gnt_eop     = fire_st ? st_if.eop : ld_if.eop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ARB_OPEN;
            last_grant_st     <= 1'b1;
            out_valid_q       <= 1'b0;
            out_pay           <= '0;
            perf_ld_beats     <= '0;
            perf_st_beats     <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (enable) begin
                out_valid_q <= fire;
                if (fire) begin
                    out_pay       <= gnt_pay;
                    last_grant_st <= fire_st;
                    if (gnt_eop)
                        state <= ARB_OPEN;
                    else
                        state <= fire_st ? ARB_LOCK_ST : ARB_LOCK_LD;
                end
            end
            if (fire_ld)
                perf_ld_beats <= perf_ld_beats + PERF_ONE;
            if (fire_st)
                perf_st_beats <= perf_st_beats + PERF_ONE;
            if (stall)
                perf_stall_cycles <= perf_stall_cycles + PERF_ONE;
        end
    end

`ifndef SYNTHESIS
    // An offered beat must stay offered, unchanged, until it is taken.
    ld_hold_a: assert property (@(posedge clk) disable iff (reset)
        (ld_if.valid && !ld_if.ready) |=> (ld_if.valid && $stable(ld_pay)));
    st_hold_a: assert property (@(posedge clk) disable iff (reset)
        (st_if.valid && !st_if.ready) |=> (st_if.valid && $stable(st_pay)));
`endif

endmodule

// File: tb/tb_lsu_commit_arb.sv
// tb_lsu_commit_arb: table-driven cycle vectors plus hand-written sequences for
// lsu_commit_arb. Accepted beats are pushed to a scoreboard queue and popped
// when the merged port hands a beat to the consumer.
module tb_lsu_commit_arb;
    localparam int NT = 4;
    localparam int NW = 2;
    localparam int NR = 5;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_commit_if #(.NUM_THREADS(NT), .NW_BITS(NW), .NR_BITS(NR)) ld_if ();
    lsu_commit_if #(.NUM_THREADS(NT), .NW_BITS(NW), .NR_BITS(NR)) st_if ();
    lsu_commit_if #(.NUM_THREADS(NT), .NW_BITS(NW), .NR_BITS(NR)) out_if ();

    logic [PW-1:0] perf_ld, perf_st, perf_stall;

    lsu_commit_arb #(.NUM_THREADS(NT), .NW_BITS(NW), .NR_BITS(NR), .PERF_W(PW)) dut (
        .clk               (clk),
        .reset             (reset),
        .ld_if             (ld_if),
        .st_if             (st_if),
        .out_if            (out_if),
        .perf_ld_beats     (perf_ld),
        .perf_st_beats     (perf_st),
        .perf_stall_cycles (perf_stall)
    );

    typedef struct packed {
        logic [NW-1:0]      wid;
        logic [NT-1:0]      tmask;
        logic [31:0]        pc;
        logic [NR-1:0]      rd;
        logic               wb;
        logic [NT*32-1:0]   data;
        logic               eop;
    } beat_t;

    typedef struct {
        bit rst, lv, le, sv, se, ordy, elr, esr, eov, pf;
        int pld, pst, pstl;
    } vec_t;

    beat_t q[$];
    vec_t  tbl[$];
    int    ld_seq = 0;
    int    st_seq = 0;
    int    checks = 0;
    int    passed = 0;

    function automatic vec_t v(bit rst, bit lv, bit le, bit sv, bit se, bit ordy,
                               bit elr, bit esr, bit eov,
                               bit pf = 0, int pld = 0, int pst = 0, int pstl = 0);
        vec_t t;
        t.rst = rst; t.lv = lv; t.le = le; t.sv = sv; t.se = se; t.ordy = ordy;
        t.elr = elr; t.esr = esr; t.eov = eov;
        t.pf = pf; t.pld = pld; t.pst = pst; t.pstl = pstl;
        return t;
    endfunction

    // Distinct, source-tagged payload for beat number seq of a stream.
    function automatic beat_t mk(bit src, int seq, bit eop);
        beat_t b;
        b.wid   = NW'(seq + (src ? 2 : 0));
        b.tmask = NT'(seq * 3 + (src ? 5 : 1));
        b.pc    = (src ? 32'h8000_0000 : 32'h4000_0000) + 32'(seq * 4);
        b.rd    = NR'(seq * 7 + (src ? 1 : 0));
        b.wb    = seq[0] ^ src;
        for (int i = 0; i < NT; i++)
            b.data[32*i +: 32] = {(src ? 8'hB0 : 8'hA0), 8'(i), 16'(seq)};
        b.eop   = eop;
        return b;
    endfunction

    function automatic beat_t out_beat();
        return {out_if.wid, out_if.tmask, out_if.pc, out_if.rd,
                out_if.wb, out_if.data, out_if.eop};
    endfunction

    task automatic check(string name, logic [191:0] act, logic [191:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(bit lv, bit le, bit sv, bit se, bit ordy);
        beat_t lb, sb;
        lb = mk(1'b0, ld_seq, le);
        sb = mk(1'b1, st_seq, se);
        ld_if.valid = lv;
        {ld_if.wid, ld_if.tmask, ld_if.pc, ld_if.rd, ld_if.wb, ld_if.data, ld_if.eop} = lb;
        st_if.valid = sv;
        {st_if.wid, st_if.tmask, st_if.pc, st_if.rd, st_if.wb, st_if.data, st_if.eop} = sb;
        out_if.ready = ordy;
    endtask

    task automatic do_reset(int n, bit chk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        if (chk) begin
            check("rst_out_valid", out_if.valid, 1'b0);
            check("rst_out_beat", out_beat(), '0);
            check("rst_perf_ld", perf_ld, '0);
            check("rst_perf_st", perf_st, '0);
            check("rst_perf_stall", perf_stall, '0);
        end
    endtask

    // One clock: drive at posedge+1, sample at negedge, book-keep after posedge.
    task automatic cyc(vec_t t);
        beat_t cur, exp;
        if (t.rst) do_reset(1, 1'b0);
        drive(t.lv, t.le, t.sv, t.se, t.ordy);
        @(negedge clk);
        check("ld_ready", ld_if.ready, t.elr);
        check("st_ready", st_if.ready, t.esr);
        check("out_valid", out_if.valid, t.eov);
        if (out_if.valid && out_if.ready) begin
            cur = out_beat();
            if (q.size() == 0) begin
                checks++;
                $display("FAIL out_beat: got %0h expected no beat", cur);
            end else begin
                exp = q.pop_front();
                check("out_beat", cur, exp);
            end
        end
        if (t.elr) q.push_back(mk(1'b0, ld_seq, t.le));
        if (t.esr) q.push_back(mk(1'b1, st_seq, t.se));
        @(posedge clk);
        #1;
        if (t.elr) ld_seq++;
        if (t.esr) st_seq++;
        if (t.pf) begin
            check("perf_ld", perf_ld, PW'(t.pld));
            check("perf_st", perf_st, PW'(t.pst));
            check("perf_stall", perf_stall, PW'(t.pstl));
        end
    endtask

    initial begin
        beat_t held;

        // rst lv le sv se ordy | elr esr eov | pf ld st stall
        // load-only stream
        tbl.push_back(v(1, 1,1, 0,0, 1,  1,0,0));
        tbl.push_back(v(0, 1,1, 0,0, 1,  1,0,1));
        tbl.push_back(v(0, 1,1, 0,0, 1,  1,0,1));
        tbl.push_back(v(0, 1,1, 0,0, 1,  1,0,1));
        tbl.push_back(v(0, 1,1, 0,0, 1,  1,0,1,  1, 5,0,0));
        tbl.push_back(v(0, 0,1, 0,0, 1,  0,0,1));
        tbl.push_back(v(0, 0,1, 0,0, 1,  0,0,0));
        // contention, alternating grants
        tbl.push_back(v(1, 1,1, 1,1, 1,  1,0,0));
        tbl.push_back(v(0, 1,1, 1,1, 1,  0,1,1));
        tbl.push_back(v(0, 1,1, 1,1, 1,  1,0,1));
        tbl.push_back(v(0, 1,1, 1,1, 1,  0,1,1));
        tbl.push_back(v(0, 1,1, 1,1, 1,  1,0,1));
        tbl.push_back(v(0, 1,1, 1,1, 1,  0,1,1,  1, 3,3,0));
        tbl.push_back(v(0, 1,1, 0,0, 1,  1,0,1));
        tbl.push_back(v(0, 0,1, 0,0, 1,  0,0,1));
        tbl.push_back(v(0, 0,1, 0,0, 1,  0,0,0));
        // 3-beat load packet holds off a waiting store
        tbl.push_back(v(1, 1,0, 1,1, 1,  1,0,0));
        tbl.push_back(v(0, 1,0, 1,1, 1,  1,0,1));
        tbl.push_back(v(0, 1,1, 1,1, 1,  1,0,1));
        tbl.push_back(v(0, 1,1, 1,1, 1,  0,1,1));
        tbl.push_back(v(0, 1,1, 0,0, 1,  1,0,1,  1, 4,1,0));
        tbl.push_back(v(0, 0,1, 0,0, 1,  0,0,1));
        tbl.push_back(v(0, 0,1, 0,0, 1,  0,0,0));
        // locked load goes idle mid-packet: store stays blocked
        tbl.push_back(v(1, 1,0, 0,0, 1,  1,0,0));
        tbl.push_back(v(0, 0,0, 1,1, 1,  0,0,1));
        tbl.push_back(v(0, 0,0, 1,1, 1,  0,0,0));
        tbl.push_back(v(0, 1,1, 1,1, 1,  1,0,0));
        tbl.push_back(v(0, 0,1, 1,1, 1,  0,1,1,  1, 2,1,0));
        tbl.push_back(v(0, 0,1, 0,1, 1,  0,0,1));
        tbl.push_back(v(0, 0,1, 0,1, 1,  0,0,0));
        // 2-beat store packet holds off a waiting load
        tbl.push_back(v(1, 0,1, 1,0, 1,  0,1,0));
        tbl.push_back(v(0, 1,1, 1,1, 1,  0,1,1));
        tbl.push_back(v(0, 1,1, 0,1, 1,  1,0,1,  1, 1,2,0));
        tbl.push_back(v(0, 0,1, 0,1, 1,  0,0,1));
        tbl.push_back(v(0, 0,1, 0,1, 1,  0,0,0));

        do_reset(2, 1'b1);
        foreach (tbl[i]) cyc(tbl[i]);

        // backpressure: 4 stalled cycles, payload held, nothing lost
        do_reset(1, 1'b0);
        held = mk(1'b0, ld_seq, 1'b1);
        cyc(v(0, 1,1, 0,0, 1,  1,0,0));
        for (int i = 0; i < 4; i++) begin
            cyc(v(0, 1,1, 0,0, 0,  0,0,1));
            check("bp_hold", out_beat(), held);
        end
        cyc(v(0, 1,1, 0,0, 1,  1,0,1));
        cyc(v(0, 0,1, 0,0, 1,  0,0,1,  1, 2,0,4));
        cyc(v(0, 0,1, 0,0, 1,  0,0,0));

        // reset mid-packet (load-locked, then store-locked): load wins the tie
        for (int s = 0; s < 2; s++) begin
            do_reset(1, 1'b0);
            cyc(v(0, s == 0,0, s == 1,0, 1,  s == 0, s == 1, 0));
            do_reset(1, 1'b1);
            cyc(v(0, 1,1, 1,1, 1,  1,0,0));
            cyc(v(0, 0,1, 1,1, 1,  0,1,1));
            cyc(v(0, 0,1, 0,1, 1,  0,0,1));
            cyc(v(0, 0,1, 0,1, 1,  0,0,0));
        end

        // counter wrap at PERF_W=4: 17 store beats leave 1
        do_reset(1, 1'b0);
        for (int i = 0; i < 17; i++)
            cyc(v(0, 0,1, 1,1, 1,  0,1, i > 0,  i == 16, 0,1,0));
        cyc(v(0, 0,1, 0,1, 1,  0,0,1));
        cyc(v(0, 0,1, 0,1, 1,  0,0,0));

        check("scoreboard_empty", 192'(q.size()), 192'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
